branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences control-flow recovery for the 5-stage pipeline. Resolves conditional
//  branches (BEQZ/BNEZ/BLTZ/BGEZ) leaving EX against the fetch-stage prediction.
//  On mispredict: flushes younger stages, drives a redirect PC into fetch until fetch
//  accepts it, then holds the pipeline for a drain window.
//  Keeps saturating branch / mispredict statistics.
// PARAMETERS
//  DATA_W        16  PC / target width
//  FLUSH_CYCLES  2   drain cycles after redirect accepted; legal 0..15
//  CNT_W         16  statistics counter width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  ex_valid      in   1       EX holds a valid instruction this cycle
//  ex_op         in   5       opcode[15:11] of EX instruction
//  Z             in   1       ALU zero flag of Rs
//  P             in   1       Rs positive (>0)
//  N             in   1       Rs negative (<0)
//  pred_taken    in   1       prediction carried with the EX instruction
//  ex_target     in   DATA_W  taken target PC
//  ex_pc_plus2   in   DATA_W  fall-through PC
//  imem_stall    in   1       fetch cannot accept a redirect this cycle
//  cnt_clr       in   1       clear statistics counters
//  flush         out  1       kill IF/ID and ID/EX contents (1-cycle pulse)
//  redirect_vld  out  1       redirect_pc valid for fetch
//  redirect_pc   out  DATA_W  corrected PC
//  hold          out  1       stall upstream stages; high whenever state != IDLE
//  br_count      out  CNT_W   resolved conditional branches
//  mis_count     out  CNT_W   mispredicted branches
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; drain counter 0.
//  Condition decode, combinational, evaluated only when ex_valid:
//  - 01100 taken=Z; 01101 taken=P|N; 01110 taken=N; 01111 taken=P|Z.
//  - Any other op: not a branch, no action.
//  Resolve (state IDLE, ex_valid, branch op) in cycle T:
//  - br_count++.
//  - mispredict = taken ^ pred_taken.
//  - correct = taken ? ex_target : ex_pc_plus2.
//  - If mispredict: mis_count++; redirect_pc <= correct; next state REDIRECT.
//  - Cycle T+1: flush=1 (one cycle only), redirect_vld=1, hold=1.
//  - Correct prediction: no state change, no flush.
//  FSM:
//  - IDLE -> REDIRECT on mispredict.
//  - REDIRECT: redirect_vld=1, redirect_pc stable. A cycle with imem_stall=0 is the
//    accept cycle. Next state is DRAIN (drain counter loaded with FLUSH_CYCLES), or
//    IDLE when FLUSH_CYCLES=0. redirect_vld drops the following cycle.
//  - DRAIN: redirect_vld=0, hold=1; decrement each cycle; -> IDLE when count hits 1.
//  - hold = (state != IDLE); flush asserted only on the IDLE->REDIRECT transition.
//  ex_valid is ignored outside IDLE: no resolve, no counting.
//  Counters saturate at all-ones.
//  cnt_clr: both counters <= 0 next cycle; wins over a same-cycle increment.
//  rst at any state forces IDLE next cycle and drops flush, redirect_vld and hold.
//  redirect_pc resets to 0 and otherwise changes only on a mispredict resolve.
// TESTING
//  1. BEQZ, Z=1, pred_taken=0, target=0x0040 -> T+1 flush=1, redirect_vld=1,
//     redirect_pc=0x0040; imem_stall=0 -> 2 DRAIN cycles; hold=0 at T+4; counts 1/1.
//  2. BNEZ, N=1, pred_taken=1 -> no flush, hold stays 0; br_count=1, mis_count=0.
//  3. BLTZ, P=1, pred_taken=1, pc+2=0x0022 -> redirect_pc=0x0022.
//     imem_stall=1 for 3 cycles -> redirect_vld held 3 cycles; accept on 4th.
//  4. Non-branch op 00000 with ex_valid=1 -> no counter change. Branch op presented
//     during REDIRECT/DRAIN -> ignored, counts unchanged.
//  5. mis_count preset to 0xFFFF, another mispredict -> stays 0xFFFF.
//     cnt_clr in the same cycle as a resolve -> both counters 0.
//  6. rst asserted in DRAIN -> next cycle IDLE, hold=0, redirect_vld=0.
//     FLUSH_CYCLES=0 build -> IDLE directly after the accept cycle.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl
// Purpose  : Resolves conditional branches leaving EX, sequences flush /
//            redirect / drain on a mispredict and keeps branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int DATA_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_op,
    input  logic              Z,
    input  logic              P,
    input  logic              N,
    input  logic              pred_taken,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] ex_pc_plus2,
    input  logic              imem_stall,
    input  logic              cnt_clr,
    output logic              flush,
    output logic              redirect_vld,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              hold,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mis_count
);

    localparam logic [1:0]       c_st_idle     = 2'd0;
    localparam logic [1:0]       c_st_redirect = 2'd1;
    localparam logic [1:0]       c_st_drain    = 2'd2;
    localparam logic [3:0]       c_drain_load  = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_drain_cnt;
    logic [3:0]        w_drain_next;
    logic              r_flush;
    logic [DATA_W-1:0] r_redirect_pc;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_mis_count;

    logic              w_is_branch;
    logic              w_taken;
    logic              w_resolve;
    logic              w_mispredict;
    logic [DATA_W-1:0] w_correct_pc;

    // Branch opcodes occupy 011xx; the low two bits select the condition.
    always_comb begin
        w_is_branch = (ex_op[4:2] == 3'b011);
        w_taken     = 1'b0;
        case (ex_op[1:0])
            2'b00:   w_taken = Z;
            2'b01:   w_taken = P | N;
            2'b10:   w_taken = N;
            default: w_taken = P | Z;
        endcase
        w_resolve    = (r_state == c_st_idle) && ex_valid && w_is_branch;
        w_mispredict = w_resolve && (w_taken ^ pred_taken);
        w_correct_pc = w_taken ? ex_target : ex_pc_plus2;
    end

    always_comb begin
        w_next_state = r_state;
        w_drain_next = r_drain_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_mispredict) begin
                    w_next_state = c_st_redirect;
                end
            end
            c_st_redirect: begin
                if (!imem_stall) begin
                    if (c_drain_load == 4'd0) begin
                        w_next_state = c_st_idle;
                    end else begin
                        w_next_state = c_st_drain;
                        w_drain_next = c_drain_load;
                    end
                end
            end
            c_st_drain: begin
                // Leave on the cycle the counter shows 1 so DRAIN lasts exactly the load value.
                if (r_drain_cnt <= 4'd1) begin
                    w_next_state = c_st_idle;
                    w_drain_next = 4'd0;
                end else begin
                    w_drain_next = r_drain_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = c_st_idle;
                w_drain_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_drain_cnt   <= 4'd0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_br_count    <= '0;
            r_mis_count   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_next;
            r_flush     <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
            if (cnt_clr) begin
                r_br_count  <= '0;
                r_mis_count <= '0;
            end else begin
                if (w_resolve && (r_br_count != c_cnt_max)) begin
                    r_br_count <= r_br_count + 1'b1;
                end
                if (w_mispredict && (r_mis_count != c_cnt_max)) begin
                    r_mis_count <= r_mis_count + 1'b1;
                end
            end
        end
    end

    assign flush        = r_flush;
    assign redirect_vld = (r_state == c_st_redirect);
    assign hold         = (r_state != c_st_idle);
    assign redirect_pc  = r_redirect_pc;
    assign br_count     = r_br_count;
    assign mis_count    = r_mis_count;

endmodule
`default_nettype wire
